vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Pixel-clock divider plus h/v counters producing VGA sync, blank and strobes.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
   parameter int H_TOTAL  = 800,
   parameter int H_SYNC   = 96,
   parameter int H_LEFT   = 144,
   parameter int H_RIGHT  = 784,
   parameter int V_TOTAL  = 521,
   parameter int V_SYNC   = 2,
   parameter int V_TOP    = 31,
   parameter int V_BOTTOM = 511,
   parameter int CLK_DIV  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic       hsync,
   output logic       vsync,
   output logic       bright,
   output logic       pix_en,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_cnt
);

   localparam int              DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]       c_H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]       c_V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]       c_H_SYNC   = 10'(H_SYNC);
   localparam logic [9:0]       c_V_SYNC   = 10'(V_SYNC);
   localparam logic [9:0]       c_H_LEFT   = 10'(H_LEFT);
   localparam logic [9:0]       c_H_RIGHT  = 10'(H_RIGHT);
   localparam logic [9:0]       c_V_TOP    = 10'(V_TOP);
   localparam logic [9:0]       c_V_BOTTOM = 10'(V_BOTTOM);

   logic [DIV_W-1:0] r_div_cnt;
   logic [DIV_W-1:0] w_div_next;
   logic [9:0]       r_hcount;
   logic [9:0]       r_vcount;
   logic [9:0]       w_h_next;
   logic [9:0]       w_v_next;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_bright;
   logic             r_line_start;
   logic             r_frame_start;
   logic [7:0]       r_frame_cnt;
   logic             w_pix_en;
   logic             w_h_wrap;
   logic             w_v_wrap;
   logic             w_line_wrap;
   logic             w_frame_wrap;

   // Gated by rst so the strobe is low during reset even when CLK_DIV=1.
   assign w_pix_en     = en & ~rst & (r_div_cnt == c_DIV_LAST);
   assign w_h_wrap     = (r_hcount == c_H_LAST);
   assign w_v_wrap     = (r_vcount == c_V_LAST);
   assign w_line_wrap  = w_pix_en & w_h_wrap;
   assign w_frame_wrap = w_line_wrap & w_v_wrap;

   always_comb begin
      w_div_next = r_div_cnt;
      w_h_next   = r_hcount;
      w_v_next   = r_vcount;
      if (en) begin
         w_div_next = (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + 1'b1;
      end
      if (w_pix_en) begin
         w_h_next = w_h_wrap ? 10'd0 : r_hcount + 10'd1;
      end
      if (w_line_wrap) begin
         w_v_next = w_v_wrap ? 10'd0 : r_vcount + 10'd1;
      end
   end

   // Sync/blank decode from next-state counters so they line up with hcount/vcount.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt     <= '0;
         r_hcount      <= '0;
         r_vcount      <= '0;
         r_hsync       <= 1'b0;
         r_vsync       <= 1'b0;
         r_bright      <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_cnt   <= '0;
      end else begin
         r_div_cnt     <= w_div_next;
         r_hcount      <= w_h_next;
         r_vcount      <= w_v_next;
         r_hsync       <= (w_h_next >= c_H_SYNC);
         r_vsync       <= (w_v_next >= c_V_SYNC);
         r_bright      <= (w_h_next >= c_H_LEFT) && (w_h_next < c_H_RIGHT) &&
                          (w_v_next >= c_V_TOP)  && (w_v_next < c_V_BOTTOM);
         r_line_start  <= w_line_wrap;
         r_frame_start <= w_frame_wrap;
         if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
      end
   end

   assign hcount      = r_hcount;
   assign vcount      = r_vcount;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign bright      = r_bright;
   assign pix_en      = w_pix_en;
   // A pulse that lands in a paused cycle is suppressed rather than stretched.
   assign line_start  = r_line_start & en;
   assign frame_start = r_frame_start & en;
   assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire
